// File: rtl/seq_det_pkg.sv
// Shared helpers for the sequence-detector family. The KMP transition and
// overlap-fallback functions are evaluated at elaboration only.
package seq_det_pkg;

  localparam int unsigned MAX_PAT_W = 16;
  localparam int unsigned STR_IDX_W = 5;
  localparam int unsigned PAT_IDX_W = 4;

  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;

  // Bit i of the pattern in arrival order (i = 0 is the first bit received)
  function automatic logic seq_det_pat_bit(input logic [MAX_PAT_W-1:0] pattern,
                                           input int pat_w, input int i);
    return pattern[PAT_IDX_W'(pat_w - 1 - i)];
  endfunction

  // KMP next state from S_k on bit b: longest pattern prefix that is a suffix of (prefix_k, b)
  function automatic int seq_det_next(input logic [MAX_PAT_W-1:0] pattern,
                                      input int pat_w, input int k, input logic b);
    logic [MAX_PAT_W:0] s;
    logic ok;
    int res;
    s   = '0;
    res = 0;
    for (int i = 0; i < MAX_PAT_W; i++) begin
      if (i < k) s[STR_IDX_W'(i)] = seq_det_pat_bit(pattern, pat_w, i);
    end
    s[STR_IDX_W'(k)] = b;
    for (int j = 1; j <= MAX_PAT_W; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int t = 0; t < MAX_PAT_W; t++) begin
          if (t < j) begin
            if (seq_det_pat_bit(pattern, pat_w, t) != s[STR_IDX_W'(k + 1 - j + t)]) ok = 1'b0;
          end
        end
        if (ok) res = j;
      end
    end
    return res;
  endfunction

  // Longest proper prefix of the pattern that is also a suffix (overlap restart point)
  function automatic int seq_det_fail(input logic [MAX_PAT_W-1:0] pattern, input int pat_w);
    logic ok;
    int res;
    res = 0;
    for (int j = 1; j < MAX_PAT_W; j++) begin
      if (j < pat_w) begin
        ok = 1'b1;
        for (int t = 0; t < MAX_PAT_W; t++) begin
          if (t < j) begin
            if (seq_det_pat_bit(pattern, pat_w, t) != seq_det_pat_bit(pattern, pat_w, pat_w - j + t)) ok = 1'b0;
          end
        end
        if (ok) res = j;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear (clear beats increment).
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] Q_MAX = '1;

  // Count register: reset/clear to zero, otherwise increment until all-ones
  always_ff @(posedge clk) begin
    if (rst)                      q <= '0;
    else if (clr)                 q <= '0;
    else if (inc && (q != Q_MAX)) q <= q + WIDTH'(1);
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Moore serial sequence detector with run-time overlap select.
// Optional match counter enabled by defining DET_COUNT_EN.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned             PAT_W   = 4,
  parameter logic [PAT_W-1:0]        PATTERN = 4'b1011,
  parameter int unsigned             CNT_W   = 8,
  parameter int unsigned             ST_W    = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             overlap_en,
  input  logic             count_clr,
  output logic             detected,
  output logic [ST_W-1:0]  prs_st,
  output logic [CNT_W-1:0] det_count
);

  localparam int               PW      = int'(PAT_W);
  localparam logic [15:0]      PAT_EXT = 16'(PATTERN);
  localparam int unsigned      TBL_N   = 2 ** ST_W;
  localparam logic [ST_W-1:0]  S_DET   = ST_W'(PAT_W);
  localparam int               FAIL_ST = seq_det_fail(PAT_EXT, PW);

  // Exits from DETECT: overlap restarts from the border state, otherwise from S0
  localparam logic [ST_W-1:0]  DET_OVL0 = ST_W'(seq_det_next(PAT_EXT, PW, FAIL_ST, 1'b0));
  localparam logic [ST_W-1:0]  DET_OVL1 = ST_W'(seq_det_next(PAT_EXT, PW, FAIL_ST, 1'b1));
  localparam logic [ST_W-1:0]  DET_NOV0 = ST_W'(seq_det_next(PAT_EXT, PW, 0, 1'b0));
  localparam logic [ST_W-1:0]  DET_NOV1 = ST_W'(seq_det_next(PAT_EXT, PW, 0, 1'b1));

  logic [ST_W-1:0] nxt_tbl0 [TBL_N];
  logic [ST_W-1:0] nxt_tbl1 [TBL_N];
  logic [ST_W-1:0] nxt_st;

  // Constant transition table for S0..S(PAT_W-1); unreachable codes fall back to S0
  for (genvar gk = 0; gk < TBL_N; gk++) begin : g_tbl
    if (gk < PAT_W) begin : g_live
      assign nxt_tbl0[gk] = ST_W'(seq_det_next(PAT_EXT, PW, gk, 1'b0));
      assign nxt_tbl1[gk] = ST_W'(seq_det_next(PAT_EXT, PW, gk, 1'b1));
    end else begin : g_dead
      assign nxt_tbl0[gk] = '0;
      assign nxt_tbl1[gk] = '0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) prs_st <= '0;
    else     prs_st <= nxt_st;
  end

  // Next-state logic: advance only on valid bits
  always_comb begin
    nxt_st = prs_st;
    if (in_valid) begin
      if (prs_st == S_DET) begin
        if (overlap_en == OVL_ON) nxt_st = in_bit ? DET_OVL1 : DET_OVL0;
        else                      nxt_st = in_bit ? DET_NOV1 : DET_NOV0;
      end else begin
        nxt_st = in_bit ? nxt_tbl1[prs_st] : nxt_tbl0[prs_st];
      end
    end
  end

  // Moore output decoded from the state register only
  always_comb begin
    detected = (prs_st == S_DET);
  end

`ifdef DET_COUNT_EN
  logic cnt_inc;

  // One count per valid step that lands in DETECT
  assign cnt_inc = in_valid && (nxt_st == S_DET);

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (count_clr),
    .inc (cnt_inc),
    .q   (det_count)
  );
`else
  logic unused_count_clr;

  // Counter absent: output tied low, clear input has no function
  assign det_count        = '0;
  assign unused_count_clr = count_clr;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three configurations (1011, saturating 11, 8-bit random).
module tb_seq_detector_param;

`ifdef DET_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef struct {
    bit rst; bit vld; bit b; bit ovl; bit clr;
    int st;  bit det; int cnt;
  } vec_t;

  typedef struct {
    int dut; int st; bit det; int cnt; string name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s [3];
  logic vld_s [3];
  logic bit_s [3];
  logic ovl_s [3];
  logic clr_s [3];

  logic       det_a, det_b, det_c;
  logic [2:0] st_a;
  logic [1:0] st_b;
  logic [3:0] st_c;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [7:0] cnt_c;

  int checks   = 0;
  int failures = 0;
  vec_t tab [$];
  exp_t sb  [$];

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst_s[0]), .in_valid(vld_s[0]), .in_bit(bit_s[0]),
    .overlap_en(ovl_s[0]), .count_clr(clr_s[0]),
    .detected(det_a), .prs_st(st_a), .det_count(cnt_a));

  seq_detector_param #(.PAT_W(2), .PATTERN(2'b11), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst_s[1]), .in_valid(vld_s[1]), .in_bit(bit_s[1]),
    .overlap_en(ovl_s[1]), .count_clr(clr_s[1]),
    .detected(det_b), .prs_st(st_b), .det_count(cnt_b));

  seq_detector_param #(.PAT_W(8), .PATTERN(8'b1010_0111), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst_s[2]), .in_valid(vld_s[2]), .in_bit(bit_s[2]),
    .overlap_en(ovl_s[2]), .count_clr(clr_s[2]),
    .detected(det_c), .prs_st(st_c), .det_count(cnt_c));

  function automatic int get_st(int d);
    if (d == 0) return int'(st_a);
    if (d == 1) return int'(st_b);
    return int'(st_c);
  endfunction

  function automatic int get_det(int d);
    if (d == 0) return int'(det_a);
    if (d == 1) return int'(det_b);
    return int'(det_c);
  endfunction

  function automatic int get_cnt(int d);
    if (d == 0) return int'(cnt_a);
    if (d == 1) return int'(cnt_b);
    return int'(cnt_c);
  endfunction

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic drive(int d, bit r, bit v, bit b, bit o, bit c);
    for (int i = 0; i < 3; i++) begin
      rst_s[i] = 1'b0; vld_s[i] = 1'b0; bit_s[i] = 1'b0; clr_s[i] = 1'b0;
    end
    rst_s[d] = r; vld_s[d] = v; bit_s[d] = b; ovl_s[d] = o; clr_s[d] = c;
  endtask

  task automatic expect_out(int d, int st, bit det, int cnt, string name);
    exp_t e;
    e.dut = d; e.st = st; e.det = det; e.cnt = cnt; e.name = name;
    sb.push_back(e);
  endtask

  // Advance one edge, then retire every queued expectation against the DUT
  task automatic tick_check();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.name, ".st"},  get_st(e.dut),  e.st);
      chk({e.name, ".det"}, get_det(e.dut), int'(e.det));
      chk({e.name, ".cnt"}, get_cnt(e.dut), CNT_ON ? e.cnt : 0);
    end
  endtask

  task automatic add(bit r, bit v, bit b, bit o, bit c, int st, bit det, int cnt);
    vec_t x;
    x.rst = r; x.vld = v; x.b = b; x.ovl = o; x.clr = c;
    x.st = st; x.det = det; x.cnt = cnt;
    tab.push_back(x);
  endtask

  task automatic run_tab(int d, string name);
    foreach (tab[i]) begin
      drive(d, tab[i].rst, tab[i].vld, tab[i].b, tab[i].ovl, tab[i].clr);
      expect_out(d, tab[i].st, tab[i].det, tab[i].cnt, $sformatf("%s[%0d]", name, i));
      tick_check();
    end
    tab.delete();
  endtask

  // Brute-force reference: longest pattern prefix ending the stream seen since restart
  function automatic int model_st(logic [7:0] hist, int avail);
    logic [7:0] pat;
    int res;
    bit ok;
    pat = 8'b1010_0111;
    res = 0;
    for (int j = 1; j <= 8; j++) begin
      if (j <= avail) begin
        ok = 1'b1;
        for (int t = 0; t < j; t++)
          if (hist[3'(j - 1 - t)] != pat[3'(7 - t)]) ok = 1'b0;
        if (ok) res = j;
      end
    end
    return res;
  endfunction

  task automatic rand_run(bit ovl, string name);
    logic [7:0] hist;
    int avail, cnt, st, n, hits;
    bit v, b;
    drive(2, 1'b1, 1'b0, 1'b0, ovl, 1'b0);
    expect_out(2, 0, 1'b0, 0, {name, ".rst"});
    tick_check();
    hist = '0; avail = 0; cnt = 0; st = 0; n = 0; hits = 0;
    while (n < 1000) begin
      v = ($urandom_range(0, 9) < 8);
      b = 1'($urandom_range(0, 1));
      if (v) begin
        hist = {hist[6:0], b};
        if (avail < 8) avail++;
        st = model_st(hist, avail);
        if (st == 8) begin
          hits++;
          if (cnt < 255) cnt++;
        end
        n++;
      end
      drive(2, 1'b0, v, b, ovl, 1'b0);
      expect_out(2, st, st == 8, cnt, $sformatf("%s[%0d]", name, n));
      tick_check();
      if (v && st == 8 && !ovl) avail = 0;
    end
    $display("%s: %0d detections in reference", name, hits);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_s[i] = 1'b1; vld_s[i] = 1'b0; bit_s[i] = 1'b0; ovl_s[i] = 1'b0; clr_s[i] = 1'b0;
    end
    for (int d = 0; d < 3; d++) expect_out(d, 0, 1'b0, 0, $sformatf("reset%0d", d));
    tick_check();

    // 1011, non-overlap, stream 1101_0110_1011_0101
    add(1,0,0,0,0, 0,0,0);
    add(0,1,1,0,0, 1,0,0); add(0,1,1,0,0, 1,0,0); add(0,1,0,0,0, 2,0,0); add(0,1,1,0,0, 3,0,0);
    add(0,1,0,0,0, 2,0,0); add(0,1,1,0,0, 3,0,0); add(0,1,1,0,0, 4,1,1); add(0,1,0,0,0, 0,0,1);
    add(0,1,1,0,0, 1,0,1); add(0,1,0,0,0, 2,0,1); add(0,1,1,0,0, 3,0,1); add(0,1,1,0,0, 4,1,2);
    add(0,1,0,0,0, 0,0,2); add(0,1,1,0,0, 1,0,2); add(0,1,0,0,0, 2,0,2); add(0,1,1,0,0, 3,0,2);
    run_tab(0, "nov_stream");

    // 1011011 with overlap: detections at bits 4 and 7
    add(1,0,0,1,0, 0,0,0);
    add(0,1,1,1,0, 1,0,0); add(0,1,0,1,0, 2,0,0); add(0,1,1,1,0, 3,0,0); add(0,1,1,1,0, 4,1,1);
    add(0,1,0,1,0, 2,0,1); add(0,1,1,1,0, 3,0,1); add(0,1,1,1,0, 4,1,2);
    run_tab(0, "ovl_1011011");

    // 1011011 without overlap: one detection, ends in S1
    add(1,0,0,0,0, 0,0,0);
    add(0,1,1,0,0, 1,0,0); add(0,1,0,0,0, 2,0,0); add(0,1,1,0,0, 3,0,0); add(0,1,1,0,0, 4,1,1);
    add(0,1,0,0,0, 0,0,1); add(0,1,1,0,0, 1,0,1); add(0,1,1,0,0, 1,0,1);
    run_tab(0, "nov_1011011");

    // Stall mid-match with toggling data and overlap_en, then stall while in DETECT
    add(1,0,0,0,0, 0,0,0);
    add(0,1,1,0,0, 1,0,0); add(0,1,0,0,0, 2,0,0); add(0,1,1,0,0, 3,0,0);
    add(0,0,0,1,0, 3,0,0); add(0,0,1,0,0, 3,0,0); add(0,0,0,1,0, 3,0,0);
    add(0,1,1,0,0, 4,1,1); add(0,0,0,0,0, 4,1,1); add(0,1,1,0,0, 1,0,1);
    run_tab(0, "stall");

    // Reset mid-match discards the partial match and clears the count
    add(0,1,0,0,0, 2,0,1); add(0,1,1,0,0, 3,0,1);
    add(1,1,1,0,0, 0,0,0); add(0,1,1,0,0, 1,0,0);
    run_tab(0, "rst_mid");

    // Pattern 11, overlap, 2-bit counter: saturation and clear precedence
    add(1,0,0,1,0, 0,0,0);
    add(0,1,1,1,0, 1,0,0); add(0,1,1,1,0, 2,1,1); add(0,1,1,1,0, 2,1,2);
    add(0,1,1,1,0, 2,1,3); add(0,1,1,1,0, 2,1,3); add(0,1,1,1,0, 2,1,3);
    add(0,1,1,1,1, 2,1,0); add(0,1,1,1,0, 2,1,1); add(0,0,0,1,1, 2,1,0);
    add(0,1,0,1,0, 0,0,0);
    run_tab(1, "sat11");

    // 8-bit pattern against the brute-force model in both modes
    rand_run(1'b1, "rand_ovl");
    rand_run(1'b0, "rand_nov");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
